// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: decoder/datapath handshake bundle for the stage sequencer
interface stage_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic push_req;
    logic pop_req;
    logic reg_write_req;
    logic mem_access;
    logic alu_multicycle;
    logic is_halt;
    logic alu_done;
    logic mem_ready;
    logic resume;
    logic [2:0] stage;
    logic pc_write;
    logic reg_write_en;
    logic push_pop_en;
    logic alu_start;
    logic mem_en;
    logic halted;
    logic mem_error;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        output push_req, pop_req, reg_write_req, mem_access, alu_multicycle, is_halt,
        output alu_done, mem_ready, resume,
        input stage, pc_write, reg_write_en, push_pop_en, alu_start, mem_en, halted,
        input mem_error, retired
    );

    modport slave (
        input push_req, pop_req, reg_write_req, mem_access, alu_multicycle, is_halt,
        input alu_done, mem_ready, resume,
        output stage, pc_write, reg_write_en, push_pop_en, alu_start, mem_en, halted,
        output mem_error, retired
    );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: multicycle IF/ID/EX/MEM/WB sequencer with stalls, HALT and memory timeout
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    stage_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IF = 3'd0,
        S_ID = 3'd1,
        S_EX = 3'd2,
        S_MEM = 3'd3,
        S_WB = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t state, state_n;
    logic rw_q, ma_q, mc_q;
    logic [7:0] tmo;
    logic timeout;
    logic mem_error_q;
    logic [CNT_WIDTH-1:0] retired_q;

    assign bus.stage = state;
    assign bus.mem_error = mem_error_q;
    assign bus.retired = retired_q;

    // next-state: fixed one-cycle stages, EX/MEM stalls, HALT until resume
    always_comb begin
        state_n = state;
        timeout = state == S_MEM && ma_q && !bus.mem_ready && tmo == 8'(MEM_TIMEOUT - 1);
        case (state)
            S_IF: state_n = S_ID;
            S_ID: state_n = bus.is_halt ? S_HALT : S_EX;
            S_EX: state_n = (!mc_q || bus.alu_done) ? S_MEM : S_EX;
            S_MEM: state_n = (!ma_q || bus.mem_ready) ? S_WB : (timeout ? S_HALT : S_MEM);
            S_WB: state_n = S_IF;
            S_HALT: state_n = bus.resume ? S_WB : S_HALT;
            default: state_n = S_IF;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IF;
        else state <= state_n;
    end

    // decode latches, MEM wait counter, sticky timeout flag and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q <= 1'b0;
            ma_q <= 1'b0;
            mc_q <= 1'b0;
            tmo <= 8'd0;
            mem_error_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state == S_ID) begin
                rw_q <= bus.reg_write_req && !bus.is_halt;
                ma_q <= bus.mem_access;
                mc_q <= bus.alu_multicycle;
            end else if (timeout) begin
                rw_q <= 1'b0;
            end
            tmo <= state == S_MEM ? tmo + 8'(!bus.mem_ready) : 8'd0;
            if (timeout) mem_error_q <= 1'b1;
            if (state == S_WB) retired_q <= retired_q + CNT_WIDTH'(1);
        end
    end

    // registered strobes decoded from the upcoming state so each lines up with its stage
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pc_write <= 1'b0;
            bus.reg_write_en <= 1'b0;
            bus.push_pop_en <= 1'b0;
            bus.alu_start <= 1'b0;
            bus.mem_en <= 1'b0;
            bus.halted <= 1'b0;
        end else begin
            bus.pc_write <= state_n == S_WB;
            bus.reg_write_en <= state_n == S_WB && rw_q;
            bus.push_pop_en <= state == S_ID && !bus.is_halt && (bus.push_req || bus.pop_req);
            bus.alu_start <= state == S_ID && !bus.is_halt && bus.alu_multicycle;
            bus.mem_en <= state_n == S_MEM && ma_q;
            bus.halted <= state_n == S_HALT;
        end
    end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed instruction traces checked cycle by cycle against a trace model
module tb_stage_sequencer;
    localparam int TMO = 15;
    localparam int CW = 3;

    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] CALL = 6'b100000;
    localparam logic [5:0] RET = 6'b010000;
    localparam logic [5:0] MUL = 6'b001010;
    localparam logic [5:0] LW = 6'b001100;
    localparam logic [5:0] HALT = 6'b000001;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stage_sequencer_if #(.CNT_WIDTH(CW)) bus();

    stage_sequencer #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic rst;
        logic [5:0] dec;
        logic done, rdy, res;
        logic chk;
        logic [2:0] stg;
        logic pcw, rwe, ppe, ast, men, hlt, err;
        logic [CW-1:0] ret;
    } row_t;

    row_t plan[$];
    row_t pending[$];
    int checks = 0;
    int errors = 0;
    int m_ret = 0;
    bit m_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void add(input logic [5:0] d, input logic dn, input logic rd, input logic rs,
                                input logic [2:0] s, input logic pcw, input logic rwe, input logic ppe,
                                input logic ast, input logic men, input logic hlt);
        row_t r;
        r.rst = 1'b0;
        r.dec = d;
        r.done = dn;
        r.rdy = rd;
        r.res = rs;
        r.chk = 1'b1;
        r.stg = s;
        r.pcw = pcw;
        r.rwe = rwe;
        r.ppe = ppe;
        r.ast = ast;
        r.men = men;
        r.hlt = hlt;
        r.err = m_err;
        r.ret = m_ret[CW-1:0];
        plan.push_back(r);
    endfunction

    function automatic void retire();
        m_ret = (m_ret + 1) % (1 << CW);
    endfunction

    // HALT: hold cycles, then the resume cycle, then a PC-only WB that retires
    function automatic void halt_seq(input logic [5:0] d, input int hold, input bit nz);
        for (int i = 0; i < hold; i++) add(d, nz, nz, 1'b0, 3'd5, 0, 0, 0, 0, 0, 1);
        add(d, nz, nz, 1'b1, 3'd5, 0, 0, 0, 0, 0, 1);
        add(d, nz, nz, nz, 3'd4, 1, 0, 0, 0, 0, 0);
        retire();
    endfunction

    // expected trace of one instruction: alu_lat = cycles from alu_start to alu_done,
    // mem_lat = MEM wait cycles before mem_ready (>= TMO means never), hold = HALT cycles before resume
    function automatic void build(input logic [5:0] d, input int alu_lat, input int mem_lat,
                                  input int hold, input bit nz);
        int ex;
        int n;
        plan.delete();
        add(d, nz, nz, nz, 3'd0, 0, 0, 0, 0, 0, 0);
        add(d, nz, nz, nz, 3'd1, 0, 0, 0, 0, 0, 0);
        if (d[0]) begin
            halt_seq(d, hold, nz);
            return;
        end
        ex = d[1] ? alu_lat + 1 : 1;
        for (int i = 0; i < ex; i++)
            add(d, d[1] ? logic'(i == ex - 1) : logic'(nz), nz, nz, 3'd2, 0, 0,
                i == 0 && (d[5] || d[4]), i == 0 && d[1], 0, 0);
        if (!d[2]) begin
            add(d, nz, nz, nz, 3'd3, 0, 0, 0, 0, 0, 0);
        end else begin
            n = mem_lat < TMO ? mem_lat + 1 : TMO;
            for (int i = 0; i < n; i++) add(d, nz, logic'(i == mem_lat), nz, 3'd3, 0, 0, 0, 0, 1, 0);
        end
        if (d[2] && mem_lat >= TMO) begin
            m_err = 1'b1;
            halt_seq(d, hold, nz);
        end else begin
            add(d, nz, nz, nz, 3'd4, 1, d[3], 0, 0, 0, 0);
            retire();
        end
    endfunction

    task automatic drive(input row_t r);
        reset = r.rst;
        {bus.push_req, bus.pop_req, bus.reg_write_req, bus.mem_access, bus.alu_multicycle, bus.is_halt} = r.dec;
        bus.alu_done = r.done;
        bus.mem_ready = r.rdy;
        bus.resume = r.res;
    endtask

    task automatic rst_cycle();
        row_t r;
        r = '{default: 0};
        r.rst = 1'b1;
        @(negedge clk);
        drive(r);
        pending.push_back(r);
        m_ret = 0;
        m_err = 1'b0;
    endtask

    // cut < 0 plays the whole trace; otherwise plays cut rows and then a reset cycle
    task automatic play(input int cut);
        int n;
        n = cut < 0 ? plan.size() : cut;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(plan[i]);
            pending.push_back(plan[i]);
        end
        if (cut >= 0) rst_cycle();
    endtask

    initial begin
        row_t r;
        forever begin
            @(negedge clk);
            #2;
            if (pending.size() > 0) begin
                r = pending.pop_front();
                if (r.chk) begin
                    chk("stage", 32'(bus.stage), 32'(r.stg));
                    chk("pc_write", 32'(bus.pc_write), 32'(r.pcw));
                    chk("reg_write_en", 32'(bus.reg_write_en), 32'(r.rwe));
                    chk("push_pop_en", 32'(bus.push_pop_en), 32'(r.ppe));
                    chk("alu_start", 32'(bus.alu_start), 32'(r.ast));
                    chk("mem_en", 32'(bus.mem_en), 32'(r.men));
                    chk("halted", 32'(bus.halted), 32'(r.hlt));
                    chk("mem_error", 32'(bus.mem_error), 32'(r.err));
                    chk("retired", 32'(bus.retired), 32'(r.ret));
                end
            end
        end
    end

    initial begin
        row_t z;
        z = '{default: 0};
        drive(z);
        reset = 1'b1;
        rst_cycle();

        build(ADDI, 0, 0, 0, 0);
        chk("addi_len", 32'(plan.size()), 32'd5);
        play(-1);
        #3;
        chk("addi_wb_stage", 32'(bus.stage), 32'd4);
        chk("addi_wb_pcw", 32'(bus.pc_write), 32'd1);
        chk("addi_wb_rwe", 32'(bus.reg_write_en), 32'd1);

        build(CALL, 0, 0, 0, 0);
        play(-1);
        #3;
        chk("call_wb_retired", 32'(bus.retired), 32'd1);
        chk("call_wb_rwe", 32'(bus.reg_write_en), 32'd0);

        build(ADDI, 0, 0, 0, 1);
        play(-1);
        build(RET, 0, 0, 0, 0);
        play(-1);

        build(MUL, 6, 0, 0, 1);
        chk("mul_len", 32'(plan.size()), 32'd11);
        play(-1);
        build(MUL, 0, 0, 0, 0);
        chk("mul_fast_len", 32'(plan.size()), 32'd5);
        play(-1);

        build(LW, 0, 3, 0, 0);
        chk("lw_len", 32'(plan.size()), 32'd8);
        play(-1);
        build(LW, 0, TMO - 1, 0, 0);
        chk("lw_edge_len", 32'(plan.size()), 32'd19);
        play(-1);

        build(LW, 0, 99, 2, 0);
        chk("tmo_len", 32'(plan.size()), 32'd22);
        play(-1);
        #3;
        chk("tmo_wb_err", 32'(bus.mem_error), 32'd1);
        chk("tmo_wb_pcw", 32'(bus.pc_write), 32'd1);
        chk("tmo_wb_rwe", 32'(bus.reg_write_en), 32'd0);
        chk("tmo_wb_retired", 32'(bus.retired), 32'd0);

        build(HALT, 0, 0, 10, 1);
        chk("halt_len", 32'(plan.size()), 32'd14);
        play(-1);

        build(MUL, 40, 0, 0, 0);
        play(5);
        build(ADDI, 0, 0, 0, 0);
        play(-1);

        build(LW, 0, 99, 3, 0);
        play(20);
        build(ADDI, 0, 0, 0, 0);
        play(-1);

        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multicycle stage sequencer for the MUSA core. Steps each instruction through IF, ID, EX, MEM and WB, and holds in EX or MEM while multicycle units are busy.
- Issues one-cycle commit strobes: PC write, register-file write and call-stack push/pop.
- Handles HALT/resume, a data-memory timeout, and a retired-instruction counter.
- Sits between the opcode decoder and the datapath enables; replaces the free-running stage counter.

Parameters:
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ready before error (1..255)
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
push_req  input  1  decoded CALL; sampled in ID
pop_req  input  1  decoded RET; sampled in ID
reg_write_req  input  1  decoded regWrite; sampled in ID
mem_access  input  1  decoded LW or SW; sampled in ID
alu_multicycle  input  1  decoded MUL or DIV; sampled in ID
is_halt  input  1  decoded HALT; sampled in ID
alu_done  input  1  multicycle ALU result valid
mem_ready  input  1  data memory access complete
resume  input  1  leave HALT state
stage  output  3  current state: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB, 5 HALT
pc_write  output  1  PC load strobe
reg_write_en  output  1  register-file write strobe
push_pop_en  output  1  call-stack push/pop strobe
alu_start  output  1  start pulse for the multicycle ALU
mem_en  output  1  data memory access enable
halted  output  1  high while in HALT
mem_error  output  1  sticky memory-timeout flag
retired  output  CNT_WIDTH  count of instructions completed through WB

Behaviour:
- All state and outputs are registered. Outputs are a Moore decode of the state plus control bits latched in ID.
- Reset (synchronous, priority over everything, valid mid-instruction):
  - stage=0 (IF); all strobes 0; halted=0; mem_error=0; retired=0; timeout counter=0; latched control bits=0.
- IF: exactly 1 cycle, then ID. No strobes asserted.
- ID: on the last ID cycle, latch push_req, pop_req, reg_write_req, mem_access, alu_multicycle and is_halt.
  - If is_halt=1: next state HALT.
  - Otherwise: next state EX.
- push_pop_en: high for exactly the cycle after ID (first EX cycle), only if latched push or pop is set. Never asserted for HALT.
- EX:
  - alu_multicycle=0: 1 cycle, then MEM.
  - alu_multicycle=1: alu_start is high in the first EX cycle only. Stay in EX until alu_done=1 is sampled, then MEM.
  - alu_done arriving in the alu_start cycle is accepted, giving a 1-cycle EX.
  - alu_done is ignored outside EX.
- MEM:
  - mem_access=0: 1 cycle, then WB; mem_en stays 0.
  - mem_access=1: mem_en is held high for every MEM cycle. The timeout counter starts at 0 on MEM entry and increments each cycle mem_ready=0.
  - mem_ready=1 sampled: next state WB. mem_en drops on the WB cycle.
  - Counter reaches MEM_TIMEOUT with mem_ready still 0: set mem_error=1 and go to HALT (no WB, no pc_write, no retire).
  - mem_ready and the timeout in the same cycle: mem_ready wins.
- WB: exactly 1 cycle, then IF.
  - pc_write=1.
  - reg_write_en=latched reg_write_req.
  - retired increments by 1 and wraps to 0 at all-ones.
- HALT: halted=1 and all strobes 0. Stay until resume=1 is sampled.
  - On resume: go to WB with reg_write_en forced 0 and pc_write=1, so the PC advances past the HALT; retired increments. Then IF.
  - mem_error is not cleared by resume (reset only). Resuming after a timeout still advances the PC.
- resume in any state other than HALT is ignored.
- Minimum latency: 5 cycles per instruction (IF, ID, EX, MEM, WB). HALT instruction: 2 cycles to reach HALT.
- pc_write, reg_write_en and push_pop_en are each high for at most one cycle per instruction.

Test Plan:
- ADDI-like instruction (reg_write_req=1, others 0) after reset -> stage sequence 0,1,2,3,4,0; pc_write and reg_write_en high only when stage=4; retired=1 after 5 cycles.
- CALL (push_req=1) -> push_pop_en high exactly one cycle, at first stage=2; reg_write_en=0; pc_write at stage=4.
- MUL (alu_multicycle=1), alu_done asserted 6 cycles after alu_start -> alu_start is a single pulse; stage holds 2 for 7 cycles; instruction total 11 cycles.
- LW with mem_ready after 3 cycles -> mem_en high 4 cycles; WB follows. Then SW with mem_ready never asserted, MEM_TIMEOUT=15 -> after 15 MEM cycles: mem_error=1, halted=1, stage=5, retired unchanged.
- HALT opcode -> stage 0,1,5; hold 10 cycles with all strobes 0; pulse resume -> stage 4 with pc_write=1 and reg_write_en=0, then 0; retired +1.
- Reset asserted while stalled in EX and in HALT -> next cycle stage=0, all outputs 0, mem_error=0; subsequent instruction runs normally.
